branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch PC value after reset.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall_i  input  1  pipeline hold request.
REQ-005 SHALL have port ex_valid_i  input  1  an instruction occupies EX this cycle.
REQ-006 SHALL have ports ex_branch_i, ex_jal_i, ex_jalr_i  input  1 each  EX instruction class.
REQ-007 SHALL have port ex_funct3_i  input  3  branch funct3.
REQ-008 SHALL have ports br_less_i, br_equal_i  input  1 each  flags from the branch comparator.
REQ-009 SHALL have port ex_target_i  input  32  ALU-computed target address.
REQ-010 SHALL have port br_unsigned_o  output  1  unsigned-compare select driven to the branch comparator.
REQ-011 SHALL have port pc_o  output  32  fetch PC register.
REQ-012 SHALL have port redirect_o  output  1  accepted taken control transfer this cycle.
REQ-013 SHALL have port flush_o  output  1  kill IF/ID contents.
REQ-014 SHALL have port illegal_br_o  output  1  branch with reserved funct3 (010/011).
REQ-015 SHALL have port taken_cnt_o  output  16  count of accepted redirects.

Function
REQ-016 br_unsigned_o SHALL equal ex_funct3_i[1], combinationally.
REQ-017 Branch condition SHALL be: 000 equal; 001 !equal; 100/110 less; 101/111 !less; 010/011 false.
REQ-018 illegal_br_o SHALL be combinational: ex_valid_i & ex_branch_i & funct3 in {010,011} & state RUN.
REQ-019 taken SHALL be ex_valid_i & state RUN & (ex_jal_i | ex_jalr_i | (ex_branch_i & condition)); redirect_o = taken, combinational.
REQ-020 Redirect target SHALL be {ex_target_i[31:2], 2'b00} for all classes (covers JALR bit-0 clear).
REQ-021 PC update priority: taken -> target (overrides stall_i); else stall_i -> hold; else pc_o + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-022 FSM states RUN, SHADOW; RUN --taken--> SHADOW; SHADOW --!stall_i--> RUN; SHADOW --stall_i--> SHADOW.
REQ-023 In SHADOW, EX inputs SHALL be ignored: no redirect, no count, no illegal flag.
REQ-024 flush_o SHALL be taken | (state == SHADOW).
REQ-025 taken_cnt_o SHALL increment by 1 on each taken cycle and saturate at 16'hFFFF.
REQ-026 Simultaneous ex_jal_i/ex_jalr_i/ex_branch_i SHALL still yield one redirect and one count increment.
REQ-027 Latency: redirect_o/flush_o same cycle as EX flags; pc_o shows the target one clock later.

Reset
REQ-028 On rst_ni low, immediately and independent of clk_i: pc_o = RESET_PC, state = RUN, taken_cnt_o = 0.
REQ-029 Reset asserted mid-SHADOW SHALL return state to RUN; after release, flush_o reflects only taken.
REQ-030 First rising edge after rst_ni release with no stall/taken SHALL give pc_o = RESET_PC + 4.

Structure
REQ-031 Package br_pkg SHALL hold funct3 constants (BEQ..BGEU), the RUN/SHADOW state enum, and the 16-bit counter width.
REQ-032 Condition decode SHALL be a combinational sub-module br_cond (funct3, less, equal -> cond, illegal).
REQ-033 Total RTL SHALL be sequential PC register, FSM and counter in branch_resolve; no other state.

Verification
REQ-034 Reset, 3 free cycles -> pc_o 0x0, 0x4, 0x8, 0xC; flush_o 0; taken_cnt_o 0.
REQ-035 BLT funct3 100, less=1, target 0x100 at pc 0x20 -> redirect_o=1, flush_o=1 two cycles, pc_o=0x100 next edge, count 1.
REQ-036 BGEU 111, less=1 -> br_unsigned_o=1, no redirect, pc_o+4; BNE 001 with equal=1 -> no redirect.
REQ-037 JALR target 0x203 while stall_i=1 -> pc_o=0x200 (stall overridden); next-cycle JAL in SHADOW ignored, count unchanged.
REQ-038 funct3 010 branch -> illegal_br_o=1, no redirect; pc_o=0xFFFF_FFFC free-run -> 0x0.
REQ-039 taken_cnt_o preloaded to 0xFFFF by 65535 redirects, one more -> stays 0xFFFF; rst_ni low in SHADOW -> RUN, pc RESET_PC, count 0 without clock.

Source files
------------

// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution slice: funct3 encodings,
// FSM state type and the taken-counter width.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int CNT_W = 16;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

endpackage

// File: rtl/br_cond.sv
// Combinational branch condition decode from funct3 and comparator flags.
module br_cond
  import br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       cond,
  output logic       illegal
);

  // Map funct3 onto the comparator flags; reserved encodings never take.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = equal;
      F3_BNE:  cond = ~equal;
      F3_BLT:  cond = less;
      F3_BLTU: cond = less;
      F3_BGE:  cond = ~less;
      F3_BGEU: cond = ~less;
      F3_RSV2: illegal = 1'b1;
      F3_RSV3: illegal = 1'b1;
      default: begin
        cond    = 1'b0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage control transfer resolution: fetch PC register, one-cycle
// redirect shadow FSM and a saturating count of accepted redirects.
module branch_resolve
  import br_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              ex_valid_i,
  input  logic              ex_branch_i,
  input  logic              ex_jal_i,
  input  logic              ex_jalr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic              br_less_i,
  input  logic              br_equal_i,
  input  logic [31:0]       ex_target_i,
  output logic              br_unsigned_o,
  output logic [31:0]       pc_o,
  output logic              redirect_o,
  output logic              flush_o,
  output logic              illegal_br_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);

  state_t     state;
  logic       cond;
  logic       illegal;
  logic       run;
  logic       taken;
  logic [31:0] target;

  br_cond u_cond (
    .funct3  (ex_funct3_i),
    .less    (br_less_i),
    .equal   (br_equal_i),
    .cond    (cond),
    .illegal (illegal)
  );

  // Redirect decision; EX contents are ignored while in the shadow cycle.
  always_comb begin
    run           = (state == RUN);
    taken         = ex_valid_i & run & (ex_jal_i | ex_jalr_i | (ex_branch_i & cond));
    target        = {ex_target_i[31:2], 2'b00};
    br_unsigned_o = ex_funct3_i[1];
    redirect_o    = taken;
    flush_o       = taken | (state == SHADOW);
    illegal_br_o  = ex_valid_i & ex_branch_i & illegal & run;
  end

  // Fetch PC: a redirect beats a stall, otherwise advance by one word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_o <= RESET_PC;
    end else if (taken) begin
      pc_o <= target;
    end else if (stall_i) begin
      pc_o <= pc_o;
    end else begin
      pc_o <= pc_o + 32'd4;
    end
  end

  // Shadow FSM: stay in SHADOW while the front end is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= taken ? SHADOW : RUN;
        SHADOW:  state <= stall_i ? SHADOW : RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of accepted redirects.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taken_cnt_o <= {CNT_W{1'b0}};
    end else if (taken && (taken_cnt_o != {CNT_W{1'b1}})) begin
      taken_cnt_o <= taken_cnt_o + 16'd1;
    end else begin
      taken_cnt_o <= taken_cnt_o;
    end
  end

endmodule
